// File: rtl/bsg_slave_reset_rx.sv
// bsg_slave_reset_rx: receives a reset level from the master side and turns it
// into a clean, registered reset for the slave core.
// Path: line -> synchronizer -> glitch filter -> ASSERTED/HOLD/RUN FSM -> flops.
// Optional feature: define BSG_SLAVE_RESET_RX_EVENT_CTR_EN to count accepted
// reset assertions seen while in RUN (saturating). Without it event_count_o is 0.
//
// state    | meaning
// ASSERTED | master holds reset, core held in reset
// HOLD     | line released, counting hold_cycles_p before letting core run
// RUN      | core out of reset, ready_o high
module bsg_slave_reset_rx #(
  parameter int sync_stages_p   = 2,
  parameter int filter_cycles_p = 4,
  parameter int hold_cycles_p   = 16,
  parameter int ctr_width_p     = 8
) (
  input  logic                   clk_i,
  input  logic                   async_reset_i,
  input  logic                   slave_reset_tline_i,
  output logic                   core_reset_o,
  output logic                   ready_o,
  output logic [ctr_width_p-1:0] event_count_o
);

  localparam int filt_w_lp = $clog2(filter_cycles_p + 1);
  localparam int hold_w_lp = $clog2(hold_cycles_p + 1);

  typedef enum logic [1:0] {
    ST_ASSERTED = 2'd0,
    ST_HOLD     = 2'd1,
    ST_RUN      = 2'd2
  } state_e;

  logic [sync_stages_p-1:0] sync_q, sync_d;
  logic                     synced;
  logic [filt_w_lp-1:0]     filt_cnt_q, filt_cnt_d;
  logic                     filtered_q, filtered_d;
  logic [hold_w_lp-1:0]     hold_cnt_q, hold_cnt_d;
  state_e                   state_q, state_d;
  logic                     core_reset_q, core_reset_d;
  logic                     ready_q, ready_d;

  assign synced = sync_q[sync_stages_p-1];

  // Shift the raw line into the synchronizer chain.
  always_comb begin
    sync_d = {sync_q[sync_stages_p-2:0], slave_reset_tline_i};
  end

  // Accept a level change only after it has persisted for filter_cycles_p cycles.
  always_comb begin
    filtered_d = filtered_q;
    filt_cnt_d = '0;
    if (synced != filtered_q) begin
      if (filt_cnt_q == filt_w_lp'(filter_cycles_p - 1)) begin
        filtered_d = synced;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  // Next-state logic; a reassertion during HOLD wins over the hold timeout.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = '0;
    unique case (state_q)
      ST_ASSERTED: begin
        if (!filtered_q) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (filtered_q) begin
          state_d = ST_ASSERTED;
        end else if (hold_cnt_q == hold_w_lp'(hold_cycles_p - 1)) begin
          state_d = ST_RUN;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (filtered_q) state_d = ST_ASSERTED;
      end
      default: state_d = ST_ASSERTED;
    endcase
    core_reset_d = (state_d != ST_RUN);
    ready_d      = (state_d == ST_RUN);
  end

  // State and datapath registers; reset parks everything in the "in reset" condition.
  always_ff @(posedge clk_i or posedge async_reset_i) begin
    if (async_reset_i) begin
      sync_q       <= '1;
      filtered_q   <= 1'b1;
      filt_cnt_q   <= '0;
      hold_cnt_q   <= '0;
      state_q      <= ST_ASSERTED;
      core_reset_q <= 1'b1;
      ready_q      <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      filtered_q   <= filtered_d;
      filt_cnt_q   <= filt_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      state_q      <= state_d;
      core_reset_q <= core_reset_d;
      ready_q      <= ready_d;
    end
  end

  assign core_reset_o = core_reset_q;
  assign ready_o      = ready_q;

`ifdef BSG_SLAVE_RESET_RX_EVENT_CTR_EN
  logic                   evt_inc;
  logic [ctr_width_p-1:0] evt_q, evt_d;

  assign evt_inc = (state_q == ST_RUN) && filtered_q;

  // Count RUN -> ASSERTED transitions, sticking at all-ones.
  always_comb begin
    evt_d = evt_q;
    if (evt_inc && (evt_q != '1)) evt_d = evt_q + 1'b1;
  end

  // Event counter register.
  always_ff @(posedge clk_i or posedge async_reset_i) begin
    if (async_reset_i) evt_q <= '0;
    else               evt_q <= evt_d;
  end

  assign event_count_o = evt_q;
`else
  assign event_count_o = '0;
`endif

endmodule

// File: tb/tb_bsg_slave_reset_rx.sv
// Testbench for bsg_slave_reset_rx: directed scenarios plus random line activity,
// all checked against a history-based behavioural model.
module tb_bsg_slave_reset_rx;

  localparam int S    = 2;
  localparam int FC   = 4;
  localparam int H    = 16;
  localparam int MAXN = 8192;

  logic       clk, rst, line;
  logic       core, ready, core2, ready2;
  logic [7:0] evt;
  logic [1:0] evt2;
  int         total = 0;
  int         bad   = 0;
  int         e;

  bsg_slave_reset_rx dut (
    .clk_i(clk), .async_reset_i(rst), .slave_reset_tline_i(line),
    .core_reset_o(core), .ready_o(ready), .event_count_o(evt)
  );

  bsg_slave_reset_rx #(.ctr_width_p(2)) dut_w2 (
    .clk_i(clk), .async_reset_i(rst), .slave_reset_tline_i(line),
    .core_reset_o(core2), .ready_o(ready2), .event_count_o(evt2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // lh[k]: line value captured at clock edge k after reset release (k<=0 reads as 1).
  // fh[k]: filtered level after edge k. Core leaves reset once filtered has been 0
  // for H+1 consecutive edges; an event is any return to reset from RUN.
  logic lh [MAXN];
  logic fh [MAXN];
  int   n;
  int   m_evt;
  logic m_core;

  function automatic logic lv(input int k);
    return (k <= 0) ? 1'b1 : lh[k];
  endfunction

  function automatic int exp_evt(input int c, input int w);
`ifdef BSG_SLAVE_RESET_RX_EVENT_CTR_EN
    int mx;
    mx = (1 << w) - 1;
    return (c > mx) ? mx : c;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    n      = 0;
    fh[0]  = 1'b1;
    m_core = 1'b1;
    m_evt  = 0;
  endtask

  task automatic model_step();
    logic v, same, nc;
    n++;
    lh[n] = line;
    v    = lv(n - S);
    same = 1'b1;
    for (int i = 0; i < FC; i++) if (lv(n - S - i) !== v) same = 1'b0;
    fh[n] = (same && (v !== fh[n-1])) ? v : fh[n-1];
    nc = 1'b1;
    if (n - H - 1 >= 1) begin
      nc = 1'b0;
      for (int k = n - H - 1; k <= n - 1; k++) if (fh[k]) nc = 1'b1;
    end
    if (!m_core && nc) m_evt++;
    m_core = nc;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else begin
        if (n >= MAXN - 2) begin
          $display("FAIL model_depth: got %0d expected below %0d", n, MAXN - 2);
          $fatal(1, "model history exhausted");
        end
        model_step();
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("core",    core,   m_core);
      chk("ready",   ready,  !m_core);
      chk("core_w2", core2,  m_core);
      chk("ready_w2",ready2, !m_core);
      chk("evt",     evt,    exp_evt(m_evt, 8));
      chk("evt_w2",  evt2,   exp_evt(m_evt, 2));
    end
  end

  // Count edges until core_reset_o reaches target (bounded).
  task automatic measure(input logic target, output int edges);
    edges = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (core === target) begin
        edges = i;
        break;
      end
    end
    if (edges < 0) chk("measure_timeout", core, target);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst  = 1'b1;
    line = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_core",  core,  1);
    chk("rst_ready", ready, 0);
    chk("rst_evt",   evt,   0);

    // Scenario 1: release with the line low -> 23 edges.
    line = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    measure(1'b0, e);
    chk("s1_release_edges", e, 23);
    chk("s1_ready", ready, 1);

    // Scenario 2: 3-cycle glitch in RUN is ignored.
    @(negedge clk);
    line = 1'b1;
    repeat (3) @(negedge clk);
    line = 1'b0;
    repeat (15) begin
      @(posedge clk);
      #1;
      chk("s2_core_low", core, 0);
    end
    chk("s2_evt", evt, exp_evt(0, 8));

    // Scenario 3: 10-cycle assertion in RUN.
    @(negedge clk);
    line = 1'b1;
    measure(1'b1, e);
    chk("s3_assert_edges", e, 7);
    repeat (4) @(negedge clk);
    line = 1'b0;
    measure(1'b0, e);
    chk("s3_release_edges", e, 23);
    chk("s3_evt", evt, exp_evt(1, 8));

    // Scenario 4: reassert on the 8th HOLD cycle, then release again.
    @(negedge clk);
    line = 1'b1;
    measure(1'b1, e);
    chk("s4_assert_edges", e, 7);
    repeat (4) @(negedge clk);
    line = 1'b0;
    repeat (14) begin
      @(negedge clk);
      chk("s4_core_held", core, 1);
    end
    line = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("s4_core_held", core, 1);
    end
    line = 1'b0;
    measure(1'b0, e);
    chk("s4_release_edges", e, 23);
    chk("s4_evt", evt, exp_evt(2, 8));

    // Scenario 5: three more full events -> five total; 2-bit counter saturates.
    repeat (3) begin
      @(negedge clk);
      line = 1'b1;
      repeat (12) @(negedge clk);
      line = 1'b0;
      repeat (30) @(negedge clk);
    end
    chk("s5_evt_w2", evt2, exp_evt(5, 2));
    chk("s5_evt",    evt,  exp_evt(5, 8));

    // Random line activity, checked cycle by cycle against the model.
    repeat (40) begin
      @(negedge clk);
      line = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 30)) @(negedge clk);
    end
    line = 1'b0;
    repeat (30) @(negedge clk);

    // Scenario 6: async reset pulse mid-RUN, between edges.
    chk("s6_pre_run", core, 0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("s6_core_async",  core,  1);
    chk("s6_ready_async", ready, 0);
    chk("s6_evt_async",   evt,   0);
    chk("s6_evt_w2_async",evt2,  0);
    @(negedge clk);
    rst = 1'b0;
    measure(1'b0, e);
    chk("s6_release_edges", e, 23);
    chk("s6_ready", ready, 1);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bsg_slave_reset_rx.md
BSG_SLAVE_RESET_RX -- requirements
Module: bsg_slave_reset_rx

Interface
REQ-001 Parameters SHALL be as follows, one per line: name, default, meaning.
- sync_stages_p, 2, synchronizer depth; legal range ≥2.
- filter_cycles_p, 4, consecutive stable cycles needed to accept a level change; legal range ≥1.
- hold_cycles_p, 16, cycles core reset is held after the line deasserts; legal range ≥1.
- ctr_width_p, 8, width of the reset-event counter.
REQ-002 Ports SHALL be as follows, one per line: name, direction, width, meaning.
- clk_i, in, 1, the single core clock.
- async_reset_i, in, 1, reset; asynchronous, active-high.
- slave_reset_tline_i, in, 1, reset level from the master side; asynchronous to clk_i.
- core_reset_o, out, 1, registered reset to the slave core.
- ready_o, out, 1, high while the slave core runs.
- event_count_o, out, ctr_width_p, count of accepted reset assertions seen while in RUN.
REQ-003 The block SHALL have one clock and one reset: clk_i, plus async_reset_i, which is asynchronous and active-high.

Function
REQ-004 slave_reset_tline_i SHALL pass through a sync_stages_p-deep flop chain; the chain output is "synced".
REQ-005 A filter counter SHALL increment on every cycle where synced != filtered, and SHALL clear on any cycle where synced == filtered.
REQ-006 filtered SHALL take the value of synced, and the filter counter SHALL clear, on the edge where the counter reaches filter_cycles_p.
REQ-007 Consequence: a synced pulse shorter than filter_cycles_p cycles SHALL have no effect.
REQ-008 The FSM SHALL have three states: ASSERTED, HOLD and RUN.
REQ-009 ASSERTED SHALL go to HOLD when filtered == 0; entering HOLD SHALL clear the hold counter.
REQ-010 In HOLD:
- filtered == 1 SHALL go to ASSERTED; this has priority.
- A hold counter equal to hold_cycles_p-1 SHALL go to RUN.
- Otherwise the hold counter SHALL increment.
REQ-011 RUN SHALL go to ASSERTED when filtered == 1.
REQ-012 core_reset_o SHALL be a dedicated flop loaded from the next-state value: 1 unless next state is RUN. It SHALL be glitch-free.
REQ-013 ready_o SHALL be a dedicated flop equal to the inverse of core_reset_o on every cycle.
REQ-014 Release latency from the falling edge of slave_reset_tline_i to the falling edge of core_reset_o SHALL be exactly sync_stages_p + filter_cycles_p + hold_cycles_p + 1 clk_i edges; this is 23 with defaults.
REQ-015 Assert latency from the rising edge of slave_reset_tline_i in RUN to the rising edge of core_reset_o SHALL be sync_stages_p + filter_cycles_p + 1 edges.
REQ-016 A reassertion of the line during HOLD SHALL abort the hold. The next release SHALL restart the full hold count from 0.
REQ-017 The hold counter SHALL be sized as clog2(hold_cycles_p+1) bits. The filter counter SHALL be sized as clog2(filter_cycles_p+1) bits. Neither counter SHALL ever wrap.

Reset
REQ-018 While async_reset_i is high, all synchronizer flops and filtered SHALL be 1.
REQ-019 While async_reset_i is high: state = ASSERTED, both counters = 0, core_reset_o = 1, ready_o = 0, event_count_o = 0.
REQ-020 Assertion of async_reset_i mid-operation SHALL force core_reset_o high immediately, without waiting for a clock edge.
REQ-021 After async_reset_i deasserts, the block SHALL require the full release sequence of REQ-014 before ready_o rises.

Configuration
REQ-022 With BSG_SLAVE_RESET_RX_EVENT_CTR_EN defined, the RUN -> ASSERTED transition SHALL increment event_count_o, saturating at all-ones.
REQ-023 Without BSG_SLAVE_RESET_RX_EVENT_CTR_EN, event_count_o SHALL be constant 0, no counter flops SHALL exist, and all other behaviour SHALL be identical.

Verification
REQ-024 Bench scenario 1:
- Stimulus: hold async_reset_i high, release it with the line low.
- Required response: core_reset_o = 1 until exactly edge 23, then 0; ready_o rises on the same edge.
REQ-025 Bench scenario 2:
- Stimulus: in RUN, a 3-cycle high pulse on the line (defaults).
- Required response: core_reset_o stays 0 and event_count_o is unchanged.
REQ-026 Bench scenario 3:
- Stimulus: in RUN, the line high for 10 cycles, then low.
- Required responses:
  - core_reset_o rises 7 edges after the line rise.
  - core_reset_o falls 23 edges after the line fall.
  - event_count_o = 1 when the counter is enabled.
REQ-027 Bench scenario 4:
- Stimulus: the line drops, then re-rises on the 8th cycle of HOLD, then drops again.
- Required response: core_reset_o stays 1 throughout, and the second release takes the full 23 edges.
REQ-028 Bench scenario 5:
- Stimulus: with ctr_width_p = 2, 5 accepted reset events.
- Required response: event_count_o saturates at 3.
REQ-029 Bench scenario 6:
- Stimulus: pulse async_reset_i mid-RUN, between clock edges.
- Required response: core_reset_o = 1 and ready_o = 0 asynchronously, and the counter is cleared to 0.
